uart_fifo: RTL and testbench

Buffered byte-stream adapter between the PDP-11 I/O register decoder and the `qcpu_uart` serial core. It holds an 8-entry transmit FIFO that feeds the UART's `start`/`din` handshake automatically, and an 8-entry receive FIFO filled from the UART's `has_byte`/`dout`/`clr_hb` handshake. Software therefore no longer polls the UART busy flag per byte. It drives a level interrupt request into the CPU `int_reqs` vector.

---
 rtl/uart_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: 8-deep TX and RX byte FIFOs wrapped around the qcpu_uart
// start/busy and has_byte/clr_hb handshakes, with a level RX interrupt.
module uart_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  wb_clk_i,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_push,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [7:0]            rx_data,
  input  logic                  rx_pop,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  rx_overrun,
  input  logic                  ovr_clr,
  input  logic                  rx_irq_en,
  output logic                  irq,
  output logic [7:0]            uart_din,
  output logic                  uart_start,
  input  logic                  uart_busy,
  input  logic [7:0]            uart_dout,
  input  logic                  uart_has_byte,
  output logic                  uart_clr_hb
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_GUARD, TX_WAIT} tx_state_t;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]            tx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
  logic [DEPTH_LOG2:0]   tx_lvl_q, tx_lvl_d;
  logic                  tx_empty, tx_pop, tx_pop_ok, tx_push_ok;
  tx_state_t             tx_state_q;
  logic                  tx_start_q;
  logic [7:0]            tx_din_q;

  assign tx_empty   = (tx_lvl_q == '0);
  assign tx_full    = (tx_lvl_q == LVL_FULL);
  assign tx_level   = tx_lvl_q;
  assign tx_pop     = (tx_state_q == TX_LOAD);
  assign tx_pop_ok  = tx_pop && !tx_empty;
  // a pop in the same cycle frees a slot, so a push at full is still accepted
  assign tx_push_ok = tx_push && (!tx_full || tx_pop_ok);

  // TX occupancy next-state
  always_comb begin
    tx_lvl_d = tx_lvl_q;
    if (tx_push_ok && !tx_pop_ok)      tx_lvl_d = tx_lvl_q + LVL_ONE;
    else if (!tx_push_ok && tx_pop_ok) tx_lvl_d = tx_lvl_q - LVL_ONE;
  end

  // TX pointers and level
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push_ok) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop_ok)  tx_rd_q <= tx_rd_q + PTR_ONE;
      tx_lvl_q <= tx_lvl_d;
    end
  end

  // TX storage write
  always_ff @(posedge wb_clk_i) begin
    if (tx_push_ok) tx_mem_q[tx_wr_q] <= tx_data;
  end

  // TX engine: start pulse and din are registered on entry to LOAD
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: if (!tx_empty && !uart_busy) begin
          tx_state_q <= TX_LOAD;
          tx_start_q <= 1'b1;
          tx_din_q   <= tx_mem_q[tx_rd_q];
        end
        TX_LOAD:  tx_state_q <= TX_GUARD;
        TX_GUARD: tx_state_q <= TX_WAIT;
        TX_WAIT:  if (!uart_busy) tx_state_q <= TX_IDLE;
        default:  tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_start = tx_start_q;
  assign uart_din   = tx_din_q;

  // ---------------- RX FIFO ----------------
  logic [7:0]            rx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
  logic [DEPTH_LOG2:0]   rx_lvl_q, rx_lvl_d;
  logic                  rx_full, rx_pop_ok, rx_push_ok;
  rx_state_t             rx_state_q;
  logic                  rx_clr_q, rx_pend_q, rx_ovr_q;
  logic [7:0]            rx_cap_q;

  assign rx_empty   = (rx_lvl_q == '0);
  assign rx_full    = (rx_lvl_q == LVL_FULL);
  assign rx_level   = rx_lvl_q;
  assign rx_data    = rx_mem_q[rx_rd_q];
  assign rx_pop_ok  = rx_pop && !rx_empty;
  assign rx_push_ok = rx_pend_q && (!rx_full || rx_pop_ok);
  assign irq        = rx_irq_en && !rx_empty;

  // RX occupancy next-state
  always_comb begin
    rx_lvl_d = rx_lvl_q;
    if (rx_push_ok && !rx_pop_ok)      rx_lvl_d = rx_lvl_q + LVL_ONE;
    else if (!rx_push_ok && rx_pop_ok) rx_lvl_d = rx_lvl_q - LVL_ONE;
  end

  // RX pointers and level
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (rx_push_ok) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop_ok)  rx_rd_q <= rx_rd_q + PTR_ONE;
      rx_lvl_q <= rx_lvl_d;
    end
  end

  // RX storage write
  always_ff @(posedge wb_clk_i) begin
    if (rx_push_ok) rx_mem_q[rx_wr_q] <= rx_cap_q;
  end

  // RX engine: the byte is captured with clr_hb and pushed one edge later
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_clr_q   <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_cap_q   <= '0;
    end else begin
      rx_clr_q  <= 1'b0;
      rx_pend_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (uart_has_byte) begin
          rx_state_q <= RX_ACK;
          rx_clr_q   <= 1'b1;
          rx_pend_q  <= 1'b1;
          rx_cap_q   <= uart_dout;
        end
        RX_ACK:  if (!uart_has_byte) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // sticky overrun; a drop in the same cycle as ovr_clr keeps it set
  always_ff @(posedge wb_clk_i) begin
    if (rst)                          rx_ovr_q <= 1'b0;
    else if (rx_pend_q && !rx_push_ok) rx_ovr_q <= 1'b1;
    else if (ovr_clr)                 rx_ovr_q <= 1'b0;
  end

  assign uart_clr_hb = rx_clr_q;
  assign rx_overrun  = rx_ovr_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: table-driven RX vectors plus TX sequences
// against a small busy-timer model of qcpu_uart.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic [3:0] tx_level;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       rx_empty;
  logic [3:0] rx_level;
  logic       rx_overrun;
  logic       ovr_clr;
  logic       rx_irq_en;
  logic       irq;
  logic [7:0] uart_din;
  logic       uart_start;
  logic       uart_busy;
  logic [7:0] uart_dout;
  logic       uart_has_byte;
  logic       uart_clr_hb;

  always #5 clk = ~clk;

  uart_fifo #(.DEPTH_LOG2(3)) dut (
    .wb_clk_i(clk), .rst(rst),
    .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full), .tx_level(tx_level),
    .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_level(rx_level),
    .rx_overrun(rx_overrun), .ovr_clr(ovr_clr), .rx_irq_en(rx_irq_en), .irq(irq),
    .uart_din(uart_din), .uart_start(uart_start), .uart_busy(uart_busy),
    .uart_dout(uart_dout), .uart_has_byte(uart_has_byte), .uart_clr_hb(uart_clr_hb)
  );

  int         total = 0;
  int         bad = 0;
  int         clr_cnt = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;
  logic [7:0] txq[$];

  // UART transmitter model: busy for 10 cycles after each start
  assign uart_busy = hold_busy | (busy_cnt != 0);
  always @(posedge clk) begin
    if (uart_start)         busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // start/clr_hb monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_start) begin
        chk("start_while_idle", uart_busy, 0);
        txq.push_back(uart_din);
      end
      if (uart_clr_hb) clr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int k = 0; k < budget && txq.size() < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic deliver(input logic [7:0] b, input logic with_pop);
    int c0;
    bit seen;
    c0 = clr_cnt;
    seen = 1'b0;
    uart_dout = b;
    uart_has_byte = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (uart_clr_hb) seen = 1'b1;
    end
    if (with_pop) rx_pop = 1'b1;   // coincides with the FIFO push edge
    tick();
    uart_has_byte = 1'b0;
    rx_pop = 1'b0;
    repeat (2) tick();
    chk("clr_hb_once", clr_cnt - c0, 1);
  endtask

  localparam int OP_D = 0, OP_DP = 1, OP_P = 2, OP_C = 3;
  typedef struct {
    int         op;
    logic [7:0] d;
    logic       en;
    logic [3:0] lvl;
    logic       emp;
    logic       irq;
    logic       ovr;
    logic [7:0] head;
  } rxv_t;
  rxv_t tbl[23];

  initial begin
    rst = 1'b1; tx_data = '0; tx_push = 1'b0; rx_pop = 1'b0; ovr_clr = 1'b0;
    rx_irq_en = 1'b1; uart_dout = '0; uart_has_byte = 1'b0;

    // RX vectors: op, byte, irq_en, then expected level/empty/irq/overrun/head
    tbl[0]  = '{OP_D,  8'h55, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[1]  = '{OP_D,  8'hAA, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'h55};
    tbl[2]  = '{OP_P,  8'h00, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'hAA};
    tbl[3]  = '{OP_P,  8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{OP_DP, 8'h11, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'h11};
    for (int k = 0; k < 7; k++)
      tbl[5 + k] = '{OP_D, 8'(8'h12 + k), 1'b1, 4'(2 + k), 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[12] = '{OP_D,  8'h99, 1'b1, 4'd8, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[13] = '{OP_C,  8'h00, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[14] = '{OP_DP, 8'h20, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 8'h12};
    for (int k = 0; k < 7; k++)
      tbl[15 + k] = '{OP_P, 8'h00, 1'b1, 4'(7 - k), 1'b0, 1'b1, 1'b0,
                      (k < 6) ? 8'(8'h13 + k) : 8'h20};
    tbl[22] = '{OP_P,  8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00};

    // reset values
    repeat (2) tick();
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_uart_start", uart_start, 0);
    chk("rst_uart_din", uart_din, 0);
    chk("rst_uart_clr_hb", uart_clr_hb, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("idle_no_start", txq.size(), 0);

    // TX ordering
    hold_busy = 1'b1;
    push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
    chk("tx_level3", tx_level, 3);
    hold_busy = 1'b0;
    wait_starts(3, 300);
    repeat (30) tick();
    chk("tx_order_count", txq.size(), 3);
    for (int k = 0; k < 3 && k < txq.size(); k++)
      chk($sformatf("tx_order_byte%0d", k), txq[k], 8'h41 + k);
    chk("tx_order_level0", tx_level, 0);
    txq.delete();

    // TX full: ninth byte dropped
    hold_busy = 1'b1;
    for (int k = 0; k < 9; k++) push_tx(8'(k));
    chk("tx_full_flag", tx_full, 1);
    chk("tx_full_level", tx_level, 8);
    hold_busy = 1'b0;
    wait_starts(8, 500);
    repeat (30) tick();
    chk("tx_full_count", txq.size(), 8);
    for (int k = 0; k < 8 && k < txq.size(); k++)
      chk($sformatf("tx_full_byte%0d", k), txq[k], k);
    chk("tx_full_drained", tx_level, 0);
    txq.delete();

    // RX table
    for (int i = 0; i < 23; i++) begin
      rx_irq_en = tbl[i].en;
      case (tbl[i].op)
        OP_D:  deliver(tbl[i].d, 1'b0);
        OP_DP: deliver(tbl[i].d, 1'b1);
        OP_P:  begin rx_pop = 1'b1; tick(); rx_pop = 1'b0; end
        default: begin ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; end
      endcase
      chk($sformatf("rx%0d_level", i), rx_level, tbl[i].lvl);
      chk($sformatf("rx%0d_empty", i), rx_empty, tbl[i].emp);
      chk($sformatf("rx%0d_irq", i), irq, tbl[i].irq);
      chk($sformatf("rx%0d_overrun", i), rx_overrun, tbl[i].ovr);
      if (!tbl[i].emp) chk($sformatf("rx%0d_head", i), rx_data, tbl[i].head);
    end

    // reset mid-queue discards TX contents and sends nothing
    hold_busy = 1'b1;
    push_tx(8'h77); push_tx(8'h78);
    chk("pre_rst_level", tx_level, 2);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("post_rst_level", tx_level, 0);
    hold_busy = 1'b0;
    repeat (20) tick();
    chk("post_rst_no_start", txq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
